// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: walks a fetch PC, issues one memory read per cycle while
// space is reserved, and queues returned words with their PCs for the issue stage.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter logic [31:0] PC_STEP   = 32'd1,
  parameter logic [31:0] NOP_INSTR = 32'h0,
  localparam int unsigned PTR_W    = $clog2(DEPTH),
  localparam int unsigned CNT_W    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_addr,
  output logic             issue_valid,
  output logic [31:0]      issue_instr,
  output logic [31:0]      issue_pc,
  output logic [CNT_W-1:0] occupancy
);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];
  logic [CNT_W:0]   reserved;
  logic             push;
  logic             pop;

  always_comb begin
    // A slot is reserved for the outstanding read so a response can never find the queue full.
    reserved = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    imem_req = rst && !redirect && (reserved < (CNT_W+1)'(DEPTH));
    imem_addr = fetch_pc_q;
    push = inflight_q && !redirect;
    pop = (count_q != '0) && !stall && !redirect;

    fetch_pc_d = fetch_pc_q;
    req_pc_d = req_pc_q;
    inflight_d = imem_req;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);

    if (imem_req) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
      req_pc_d = fetch_pc_q;
    end
    if (redirect) begin
      fetch_pc_d = redirect_addr;
      count_d = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      count_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      count_q <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    req_pc_q <= req_pc_d;
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q] <= req_pc_q;
    end
  end

  always_comb begin
    issue_valid = (count_q != '0);
    issue_instr = issue_valid ? instr_mem[rd_ptr_q] : NOP_INSTR;
    issue_pc = issue_valid ? pc_mem[rd_ptr_q] : 32'h0;
    occupancy = count_q;
  end

  overflow_a: assert property (@(posedge clk) disable iff (!rst)
    push |-> (count_q != CNT_W'(DEPTH)));

endmodule
